// File: rtl/my_modulation_pkg.sv
// Shared definitions for the square-wave modulation generator: state encoding
// and default widths.
package my_modulation_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefCntW  = 32;
  localparam int unsigned DefDlyW  = 16;

  // DEAD_HL / DEAD_LH are only reachable when MOD_DEADBAND_EN is defined.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALF_H  = 3'd1,
    HALF_L  = 3'd2,
    DEAD_HL = 3'd3,
    DEAD_LH = 3'd4
  } mod_state_e;

endpackage

// File: rtl/my_mod_trig_delay.sv
// Loadable down-counter producing a single registered pulse when the loaded
// delay expires. A new load restarts the count and drops any pending pulse.
module my_mod_trig_delay #(
  parameter int unsigned DLY_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [DLY_W-1:0] i_dly,
  output logic             o_pulse
);

  localparam logic [DLY_W-1:0] DlyOne = 1;

  logic [DLY_W-1:0] r_cnt;
  logic             r_armed;
  logic             r_pulse;

  // Load / count down / fire once; a zero delay fires in the cycle after the load edge.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= i_dly;
      r_armed <= (i_dly != '0);
      r_pulse <= (i_dly == '0);
    end else if (r_armed) begin
      r_cnt   <= r_cnt - DlyOne;
      r_armed <= (r_cnt != DlyOne);
      r_pulse <= (r_cnt == DlyOne);
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/my_modulation_gen_v2.sv
// Square-wave modulation generator with shadowed parameters that reload only
// at full-cycle boundaries, plus a delayed per-edge step trigger.
// Optional dead band between halves: define MOD_DEADBAND_EN.
module my_modulation_gen_v2
  import my_modulation_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned DLY_W  = DefDlyW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic        [CNT_W-1:0]  i_freq_cnt,
  input  logic signed [DATA_W-1:0] i_amp_H,
  input  logic signed [DATA_W-1:0] i_amp_L,
  input  logic        [DLY_W-1:0]  i_trig_dly,
  input  logic        [CNT_W-1:0]  i_dead_cnt,
  output logic signed [DATA_W-1:0] o_mod_out,
  output logic                     o_status,
  output logic                     o_stepTrig,
  output logic                     o_cycle_done,
  output logic                     o_busy
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  mod_state_e               r_state, w_state_d;
  logic        [CNT_W-1:0]  r_cnt, w_cnt_d, r_sh_freq;
  logic signed [DATA_W-1:0] r_sh_amp_h, r_sh_amp_l, r_mod_out, w_mod_d;
  logic        [DLY_W-1:0]  r_sh_dly, w_trig_dly;
  logic                     r_status;
  logic                     w_last, w_reload, w_half_entry, w_trig_clr;

`ifdef MOD_DEADBAND_EN
  logic [CNT_W-1:0] r_sh_dead;
  logic             w_dead_zero, w_dead_last;
  assign w_dead_zero = (r_sh_dead == '0);
  assign w_dead_last = (r_cnt == r_sh_dead - CntOne);
`else
  logic w_unused_dead;
  assign w_unused_dead = ^i_dead_cnt;
`endif

  assign w_last = (r_cnt == r_sh_freq);

  // Next-state decode; a low enable overrides everything and returns to IDLE.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:   w_state_d = HALF_H;
      HALF_H: begin
        if (w_last) begin
`ifdef MOD_DEADBAND_EN
          w_state_d = w_dead_zero ? HALF_L : DEAD_HL;
`else
          w_state_d = HALF_L;
`endif
        end
      end
      HALF_L: begin
        if (w_last) begin
`ifdef MOD_DEADBAND_EN
          w_state_d = w_dead_zero ? HALF_H : DEAD_LH;
`else
          w_state_d = HALF_H;
`endif
        end
      end
`ifdef MOD_DEADBAND_EN
      DEAD_HL: if (w_dead_last) w_state_d = HALF_L;
      DEAD_LH: if (w_dead_last) w_state_d = HALF_H;
`endif
      default: w_state_d = IDLE;
    endcase
    if (!i_en) w_state_d = IDLE;
  end

  // Every HALF_H entry starts a new full cycle, so that is where shadows reload.
  assign w_reload     = (w_state_d == HALF_H) && (r_state != HALF_H);
  assign w_half_entry = ((w_state_d == HALF_H) || (w_state_d == HALF_L)) &&
                        (w_state_d != r_state);
  assign w_cnt_d      = ((w_state_d != r_state) || (w_state_d == IDLE)) ? '0 : r_cnt + CntOne;
  assign w_trig_dly   = w_reload ? i_trig_dly : r_sh_dly;
  assign w_trig_clr   = !i_en;

  // Output level for the upcoming state; on reload the fresh input bypasses the shadow.
  always_comb begin
    w_mod_d = '0;
    case (w_state_d)
      HALF_H:  w_mod_d = w_reload ? i_amp_H : r_sh_amp_h;
      HALF_L:  w_mod_d = r_sh_amp_l;
      default: w_mod_d = '0;
    endcase
  end

  // State, counter, shadows and registered outputs advance together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sh_freq  <= '0;
      r_sh_amp_h <= '0;
      r_sh_amp_l <= '0;
      r_sh_dly   <= '0;
`ifdef MOD_DEADBAND_EN
      r_sh_dead  <= '0;
`endif
      r_mod_out  <= '0;
      r_status   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_mod_out <= w_mod_d;
      r_status  <= (w_state_d == HALF_H);
      if (w_reload) begin
        r_sh_freq  <= i_freq_cnt;
        r_sh_amp_h <= i_amp_H;
        r_sh_amp_l <= i_amp_L;
        r_sh_dly   <= i_trig_dly;
`ifdef MOD_DEADBAND_EN
        r_sh_dead  <= i_dead_cnt;
`endif
      end
    end
  end

  my_mod_trig_delay #(
    .DLY_W (DLY_W)
  ) u_trig_delay (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_trig_clr),
    .i_load  (w_half_entry),
    .i_dly   (w_trig_dly),
    .o_pulse (o_stepTrig)
  );

  // Last cycle before HALF_H re-entry.
`ifdef MOD_DEADBAND_EN
  assign o_cycle_done = ((r_state == HALF_L) && w_last && w_dead_zero) ||
                        ((r_state == DEAD_LH) && w_dead_last);
`else
  assign o_cycle_done = (r_state == HALF_L) && w_last;
`endif

  assign o_mod_out = r_mod_out;
  assign o_status  = r_status;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_my_modulation_gen_v2.sv
// Randomized scoreboard bench for my_modulation_gen_v2. The reference model
// tracks position within the full period and the time since the last edge.
module tb_my_modulation_gen_v2;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_en = 1'b0;
  logic        [31:0] i_freq_cnt = '0;
  logic signed [31:0] i_amp_H = '0;
  logic signed [31:0] i_amp_L = '0;
  logic        [15:0] i_trig_dly = '0;
  logic        [31:0] i_dead_cnt = '0;
  logic signed [31:0] o_mod_out;
  logic               o_status, o_stepTrig, o_cycle_done, o_busy;

  my_modulation_gen_v2 dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_freq_cnt   (i_freq_cnt),
    .i_amp_H      (i_amp_H),
    .i_amp_L      (i_amp_L),
    .i_trig_dly   (i_trig_dly),
    .i_dead_cnt   (i_dead_cnt),
    .o_mod_out    (o_mod_out),
    .o_status     (o_status),
    .o_stepTrig   (o_stepTrig),
    .o_cycle_done (o_cycle_done),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic signed [31:0] mod;
    logic               status;
    logic               trig;
    logic               done;
    logic               busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: latched parameters and position within the period.
  longint p_f, p_dly, p_dead;
  logic signed [31:0] p_h, p_l;
  bit     m_run = 0, m_pend = 0;
  longint m_pos = 0, m_t = 0, m_entry = 0, m_edly = 0;

  function automatic longint period();
    return 2 * (p_f + 1) + 2 * p_dead;
  endfunction

  task automatic latch();
    p_f   = longint'(i_freq_cnt);
    p_h   = i_amp_H;
    p_l   = i_amp_L;
    p_dly = longint'(i_trig_dly);
`ifdef MOD_DEADBAND_EN
    p_dead = longint'(i_dead_cnt);
`else
    p_dead = 0;
`endif
  endtask

  // One clock edge of the model, using the inputs the DUT sampled on that edge.
  task automatic model_step();
    exp_t   e;
    longint h, d, per;
    e = '0;
    m_t++;
    if (i_rst || !i_en) begin
      m_run  = 0;
      m_pend = 0;
    end else begin
      if (!m_run) begin
        m_run = 1;
        m_pos = 0;
        latch();
      end else begin
        m_pos++;
        if (m_pos == period()) begin
          m_pos = 0;
          latch();
        end
      end
      h   = p_f + 1;
      d   = p_dead;
      per = period();
      if (m_pos < h) begin
        e.mod    = p_h;
        e.status = 1'b1;
      end else if (m_pos >= h + d && m_pos < 2 * h + d) begin
        e.mod = p_l;
      end
      e.done = (m_pos == per - 1);
      e.busy = 1'b1;
      if (m_pos == 0 || m_pos == h + d) begin
        m_pend  = 1;
        m_entry = m_t;
        m_edly  = p_dly;
      end
      if (m_pend && (m_t - m_entry == m_edly)) begin
        e.trig = 1'b1;
        m_pend = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      model_step();
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(req), $time);
    end
  endtask

  // Monitor: every settled cycle pops one expectation and compares all outputs.
  initial begin
    exp_t e;
    @(posedge i_clk);
    forever begin
      @(negedge i_clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("mod_out", o_mod_out, e.mod);
        chk("status", {31'd0, o_status}, {31'd0, e.status});
        chk("stepTrig", {31'd0, o_stepTrig}, {31'd0, e.trig});
        chk("cycle_done", {31'd0, o_cycle_done}, {31'd0, e.done});
        chk("busy", {31'd0, o_busy}, {31'd0, e.busy});
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized parameter churn.
  initial begin
    i_rst = 1'b1;
    tick(3);
    i_rst      = 1'b0;
    i_en       = 1'b1;
    i_freq_cnt = 3;
    i_amp_H    = 1000;
    i_amp_L    = -1000;
    i_trig_dly = 0;
    i_dead_cnt = 2;
    tick(34);
    // Mid-HALF_H update; takes effect at the next full-cycle boundary.
    i_amp_H    = 500;
    i_freq_cnt = 1;
    tick(20);
    i_freq_cnt = 9;
    i_trig_dly = 3;
    tick(50);
    // Delay longer than a half: every pending trigger is restarted before firing.
    i_trig_dly = 12;
    tick(50);
    i_trig_dly = 3;
    tick(27);
    // Drop enable mid-cycle, then re-enable.
    i_en = 1'b0;
    tick(3);
    i_en = 1'b1;
    tick(15);
    // Reset while a trigger is pending.
    i_trig_dly = 7;
    tick(13);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    i_en  = 1'b0;
    tick(12);
    i_en = 1'b1;
    tick(5);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) begin
        i_freq_cnt = $urandom_range(5);
        i_amp_H    = $urandom;
        i_amp_L    = $urandom;
        i_trig_dly = 16'($urandom_range(11));
        i_dead_cnt = $urandom_range(3);
      end
      i_en  = ($urandom_range(19) != 0);
      i_rst = ($urandom_range(99) == 0);
      tick(1);
    end
    i_rst = 1'b0;
    i_en  = 1'b0;
    tick(2);
    @(negedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
